// File: rtl/counter5_pkg.sv
// Shared constants and types for the counter5 stopwatch digit stage.
package counter5_pkg;

    localparam int unsigned MAX_VALUE_DEFAULT = 5;
    localparam int unsigned WIDTH_DEFAULT     = 4;

    typedef logic [WIDTH_DEFAULT-1:0] count_t;

endpackage : counter5_pkg

// File: rtl/counter5_next.sv
// Combinational next-count and wrap computation for the modulo counter.
// Outputs are combinational (suffix _c); the parent registers them.
module counter5_next
    import counter5_pkg::*;
#(
    parameter int unsigned MAX_VALUE = MAX_VALUE_DEFAULT,
    parameter int unsigned WIDTH     = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             enable,
    output logic [WIDTH-1:0] next_q_c,
    output logic             wrap_c
);

    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Step up or down by one, wrapping at the ends of 0..MAX_VALUE.
    always_comb begin
        next_q_c = q;
        wrap_c   = 1'b0;
        if (enable) begin
            if (up) begin
                if (q == TOP) begin
                    next_q_c = ZERO;
                    wrap_c   = 1'b1;
                end else begin
                    next_q_c = q + ONE;
                end
            end else begin
                if (q == ZERO) begin
                    next_q_c = TOP;
                    wrap_c   = 1'b1;
                end else begin
                    next_q_c = q - ONE;
                end
            end
        end
    end

endmodule : counter5_next

// File: rtl/counter5.sv
// counter5: modulo-(MAX_VALUE+1) up/down digit stage with parallel load and
// a one-cycle wrap pulse for cascading.
// Build option: COUNTER5_LOAD_CLAMP_EN -- when defined, an out-of-range load
// saturates to MAX_VALUE; otherwise such a load is ignored (q holds).
module counter5
    import counter5_pkg::*;
#(
    parameter int unsigned MAX_VALUE = MAX_VALUE_DEFAULT,
    parameter int unsigned WIDTH     = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_signal,
    output logic [WIDTH-1:0] q,
    output logic             next_counter_clk
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] count_next_c;
    logic             count_wrap_c;
    logic [WIDTH-1:0] q_d_c;
    logic             pulse_d_c;
    logic             load_in_range_c;

    counter5_next #(
        .MAX_VALUE (MAX_VALUE),
        .WIDTH     (WIDTH)
    ) u_next (
        .q        (q),
        .up       (up),
        .enable   (enable),
        .next_q_c (count_next_c),
        .wrap_c   (count_wrap_c)
    );

    assign load_in_range_c = (load_signal <= TOP);

    // Select load value (with out-of-range policy) over counting; loads never pulse.
    always_comb begin
        q_d_c     = count_next_c;
        pulse_d_c = count_wrap_c;
        if (load) begin
            pulse_d_c = 1'b0;
            if (load_in_range_c) begin
                q_d_c = load_signal;
            end else begin
`ifdef COUNTER5_LOAD_CLAMP_EN
                q_d_c = TOP;
`else
                q_d_c = q;
`endif
            end
        end
    end

    // Count and wrap-pulse registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q                <= '0;
            next_counter_clk <= 1'b0;
        end else begin
            q                <= q_d_c;
            next_counter_clk <= pulse_d_c;
        end
    end

endmodule : counter5

// File: tb/tb_counter5.sv
// Directed self-checking bench for counter5 (default MAX_VALUE=5, WIDTH=4).
module tb_counter5;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up;
    logic       load;
    logic [3:0] load_signal;
    logic [3:0] q;
    logic       next_counter_clk;

    int pass_cnt;
    int total_cnt;

    counter5 dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .up               (up),
        .load             (load),
        .load_signal      (load_signal),
        .q                (q),
        .next_counter_clk (next_counter_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int exp_q [7] = '{1, 2, 3, 4, 5, 0, 1};
        int exp_p [7] = '{0, 0, 0, 0, 0, 1, 0};
        reset = 1'b0; enable = 1'b1; up = 1'b1; load = 1'b0; load_signal = 4'd0;
        #2;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (q !== 4'd0 || next_counter_clk !== 1'b0)
                $display("FAIL reset_hold[%0d]: q=%0d pulse=%b, want q=0 pulse=0", i, q, next_counter_clk);
            else pass_cnt++;
        end
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            total_cnt++;
            if (q !== 4'(exp_q[i]) || next_counter_clk !== 1'(exp_p[i]))
                $display("FAIL up_wrap[%0d]: q=%0d pulse=%b, want q=%0d pulse=%0d", i, q, next_counter_clk, exp_q[i], exp_p[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_load();
        int exp_q [4] = '{4, 5, 0, 1};
        int exp_p [4] = '{0, 0, 1, 0};
        load = 1'b1; load_signal = 4'd3; enable = 1'b1; up = 1'b1;
        tick();
        total_cnt++;
        if (q !== 4'd3 || next_counter_clk !== 1'b0)
            $display("FAIL load3: q=%0d pulse=%b, want q=3 pulse=0", q, next_counter_clk);
        else pass_cnt++;
        load = 1'b0; enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (q !== 4'd3 || next_counter_clk !== 1'b0)
                $display("FAIL hold[%0d]: q=%0d pulse=%b, want q=3 pulse=0", i, q, next_counter_clk);
            else pass_cnt++;
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if (q !== 4'(exp_q[i]) || next_counter_clk !== 1'(exp_p[i]))
                $display("FAIL load_count[%0d]: q=%0d pulse=%b, want q=%0d pulse=%0d", i, q, next_counter_clk, exp_q[i], exp_p[i]);
            else pass_cnt++;
        end
        // Loading the wrap target from 1 must not pulse.
        load = 1'b1; load_signal = 4'd0;
        tick();
        total_cnt++;
        if (q !== 4'd0 || next_counter_clk !== 1'b0)
            $display("FAIL load0_nopulse: q=%0d pulse=%b, want q=0 pulse=0", q, next_counter_clk);
        else pass_cnt++;
        load = 1'b0;
    endtask

    task automatic test_down();
        int exp_q [10] = '{5, 4, 3, 2, 1, 0, 5, 4, 5, 4};
        int exp_p [10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        enable = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        up = 1'b0; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            // Reverse direction for one step near the end.
            up = (i == 8) ? 1'b1 : 1'b0;
            tick();
            total_cnt++;
            if (q !== 4'(exp_q[i]) || next_counter_clk !== 1'(exp_p[i]))
                $display("FAIL down[%0d]: q=%0d pulse=%b, want q=%0d pulse=%0d", i, q, next_counter_clk, exp_q[i], exp_p[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0] exp;
        // q is 4 here.
        load = 1'b1; enable = 1'b1; up = 1'b1; load_signal = 4'd6;
`ifdef COUNTER5_LOAD_CLAMP_EN
        exp = 4'd5;
`else
        exp = 4'd4;
`endif
        tick();
        total_cnt++;
        if (q !== exp || next_counter_clk !== 1'b0)
            $display("FAIL oor6: q=%0d pulse=%b, want q=%0d pulse=0", q, next_counter_clk, exp);
        else pass_cnt++;
        load_signal = 4'd2;
        tick();
        total_cnt++;
        if (q !== 4'd2)
            $display("FAIL load2: q=%0d, want 2", q);
        else pass_cnt++;
        load_signal = 4'd9;
`ifdef COUNTER5_LOAD_CLAMP_EN
        exp = 4'd5;
`else
        exp = 4'd2;
`endif
        tick();
        total_cnt++;
        if (q !== exp || next_counter_clk !== 1'b0)
            $display("FAIL oor9: q=%0d pulse=%b, want q=%0d pulse=0", q, next_counter_clk, exp);
        else pass_cnt++;
        load_signal = 4'd5;
        tick();
        total_cnt++;
        if (q !== 4'd5 || next_counter_clk !== 1'b0)
            $display("FAIL load_max: q=%0d pulse=%b, want q=5 pulse=0", q, next_counter_clk);
        else pass_cnt++;
        load = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_signal = 4'd4; enable = 1'b0; up = 1'b1;
        tick();
        load = 1'b0;
        total_cnt++;
        if (q !== 4'd4)
            $display("FAIL pre_async: q=%0d, want 4", q);
        else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        total_cnt++;
        if (q !== 4'd0 || next_counter_clk !== 1'b0)
            $display("FAIL async_clear: q=%0d pulse=%b, want q=0 pulse=0", q, next_counter_clk);
        else pass_cnt++;
        reset = 1'b1;
        // Build a wrap pulse, then reset in the middle of it.
        load = 1'b1; load_signal = 4'd5;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        total_cnt++;
        if (q !== 4'd0 || next_counter_clk !== 1'b1)
            $display("FAIL pulse_setup: q=%0d pulse=%b, want q=0 pulse=1", q, next_counter_clk);
        else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        total_cnt++;
        if (next_counter_clk !== 1'b0)
            $display("FAIL pulse_clear: pulse=%b, want 0", next_counter_clk);
        else pass_cnt++;
        load = 1'b1; load_signal = 4'd3;
        tick();
        total_cnt++;
        if (q !== 4'd0 || next_counter_clk !== 1'b0)
            $display("FAIL reset_blocks_load: q=%0d pulse=%b, want q=0 pulse=0", q, next_counter_clk);
        else pass_cnt++;
        load = 1'b0; reset = 1'b1;
        tick();
        total_cnt++;
        if (q !== 4'd1 || next_counter_clk !== 1'b0)
            $display("FAIL first_edge: q=%0d pulse=%b, want q=1 pulse=0", q, next_counter_clk);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_load();
        test_down();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_counter5
